// File: rtl/mcu_control_unit.sv
// Sequencing controller for the 8-bit accumulator MicroController: owns PC and IR and
// steps each instruction through FETCH, DECODE and EXEC, driving registered datapath strobes.
module mcu_control_unit #(
    parameter int PC_W = 8,
    parameter int IR_W = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IR_W-1:0] pmem_data,
    input  logic            acc_zero,
    output logic [PC_W-1:0] pmem_addr,
    output logic [IR_W-1:0] ir,
    output logic [IR_W-5:0] dmem_addr,
    output logic            dmem_we,
    output logic            acc_we,
    output logic [1:0]      alu_op,
    output logic            alu_src,
    output logic            halted,
    output logic [1:0]      state
);

    localparam int OPND_W = IR_W - 4;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDM  = 4'h2;
    localparam logic [3:0] OP_STM  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JNZ  = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ALU_PASS_B = 2'd0;
    localparam logic [1:0] ALU_ADD    = 2'd1;
    localparam logic [1:0] ALU_SUB    = 2'd2;
    localparam logic [1:0] ALU_AND    = 2'd3;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic              acc_we_q, acc_we_d;
    logic              dmem_we_q, dmem_we_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic              alu_src_q, alu_src_d;
    logic              halted_q, halted_d;

    logic [3:0]        opcode;
    logic [OPND_W-1:0] operand;

    assign opcode  = ir_q[IR_W-1:IR_W-4];
    assign operand = ir_q[OPND_W-1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        acc_we_d  = 1'b0;
        dmem_we_d = 1'b0;
        alu_op_d  = ALU_PASS_B;
        alu_src_d = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ir_d    = pmem_data;
                pc_d    = pc_q + 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
                if ((opcode == OP_JMP) ||
                    (opcode == OP_JZ  &&  acc_zero) ||
                    (opcode == OP_JNZ && !acc_zero)) begin
                    pc_d = PC_W'(operand);
                end
            end
            default: state_d = ST_HALT;
        endcase

        // Strobes are registered: decode them for the cycle about to become EXEC.
        if (state_d == ST_EXEC) begin
            case (opcode)
                OP_LDI:  begin acc_we_d = 1'b1; alu_op_d = ALU_PASS_B; alu_src_d = 1'b1; end
                OP_LDM:  begin acc_we_d = 1'b1; alu_op_d = ALU_PASS_B; end
                OP_STM:  dmem_we_d = 1'b1;
                OP_ADD:  begin acc_we_d = 1'b1; alu_op_d = ALU_ADD; end
                OP_SUB:  begin acc_we_d = 1'b1; alu_op_d = ALU_SUB; end
                OP_AND:  begin acc_we_d = 1'b1; alu_op_d = ALU_AND; end
                OP_ADDI: begin acc_we_d = 1'b1; alu_op_d = ALU_ADD; alu_src_d = 1'b1; end
                default: ;
            endcase
        end

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            acc_we_q  <= 1'b0;
            dmem_we_q <= 1'b0;
            alu_op_q  <= ALU_PASS_B;
            alu_src_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            acc_we_q  <= acc_we_d;
            dmem_we_q <= dmem_we_d;
            alu_op_q  <= alu_op_d;
            alu_src_q <= alu_src_d;
            halted_q  <= halted_d;
        end
    end

    assign pmem_addr = pc_q;
    assign ir        = ir_q;
    assign dmem_addr = operand;
    assign dmem_we   = dmem_we_q;
    assign acc_we    = acc_we_q;
    assign alu_op    = alu_op_q;
    assign alu_src   = alu_src_q;
    assign halted    = halted_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mcu_control_unit.sv
// Testbench for mcu_control_unit: a simple accumulator datapath around the DUT plus an
// instruction-level reference model that predicts every cycle of every instruction.
module tb_mcu_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pmem_data;
    logic        acc_zero;
    logic [7:0]  pmem_addr;
    logic [11:0] ir;
    logic [7:0]  dmem_addr;
    logic        dmem_we;
    logic        acc_we;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        halted;
    logic [1:0]  state;

    mcu_control_unit #(.PC_W(8), .IR_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .pmem_data (pmem_data),
        .acc_zero  (acc_zero),
        .pmem_addr (pmem_addr),
        .ir        (ir),
        .dmem_addr (dmem_addr),
        .dmem_we   (dmem_we),
        .acc_we    (acc_we),
        .alu_op    (alu_op),
        .alu_src   (alu_src),
        .halted    (halted),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Program memory with combinational read
    logic [11:0] prog [256];
    assign pmem_data = prog[pmem_addr];

    // Surrounding datapath: accumulator, ALU, synchronous-read data memory
    logic [7:0] envAcc;
    logic [7:0] envRd;
    logic [7:0] envMem [256] = '{default: 8'h00};
    logic [7:0] aluB;

    assign aluB     = alu_src ? ir[7:0] : envRd;
    assign acc_zero = (envAcc == 8'h00);

    always @(posedge clk) begin
        if (reset) begin
            envAcc <= 8'h00;
        end else if (acc_we) begin
            case (alu_op)
                2'd0: envAcc <= aluB;
                2'd1: envAcc <= envAcc + aluB;
                2'd2: envAcc <= envAcc - aluB;
                default: envAcc <= envAcc & aluB;
            endcase
        end
        if (dmem_we) envMem[dmem_addr] <= envAcc;
        envRd <= envMem[dmem_addr];
    end

    // Reference model state (instruction level)
    logic [7:0]  mPc;
    logic [7:0]  mAcc;
    logic [7:0]  mMem [256];
    logic [11:0] mIr;

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // {acc_we, dmem_we, alu_op, alu_src} expected in EXEC for each opcode
    function automatic logic [4:0] expectStrobes(input logic [3:0] op);
        case (op)
            4'h1: return 5'b1_0_00_1;
            4'h2: return 5'b1_0_00_0;
            4'h3: return 5'b0_1_00_0;
            4'h4: return 5'b1_0_01_0;
            4'h5: return 5'b1_0_10_0;
            4'h6: return 5'b1_0_11_0;
            4'h7: return 5'b1_0_01_1;
            default: return 5'b0_0_00_0;
        endcase
    endfunction

    task automatic clearProg();
        for (int i = 0; i < 256; i++) prog[i] = 12'h000;
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_state", state, 2'd0);
        checkOutput("rst_pc", pmem_addr, 8'h00);
        checkOutput("rst_ir", ir, 12'h000);
        checkOutput("rst_strobes", {acc_we, dmem_we, alu_op, alu_src, halted}, 6'd0);
        reset = 1'b0;
        mPc  = 8'h00;
        mAcc = 8'h00;
        mIr  = 12'h000;
    endtask

    // Runs one instruction from mid-FETCH to mid-FETCH (or mid-HALT), checking every cycle
    task automatic runInstr(output bit hitHalt);
        logic [11:0] inst;
        logic [3:0]  op;
        logic [7:0]  opnd;
        logic [7:0]  nextPc;
        hitHalt = 1'b0;
        inst    = prog[mPc];
        op      = inst[11:8];
        opnd    = inst[7:0];
        nextPc  = mPc + 8'd1;

        checkOutput("fetch_state", state, 2'd0);
        checkOutput("fetch_pc", pmem_addr, mPc);
        checkOutput("fetch_strobes", {acc_we, dmem_we, alu_op, alu_src, halted}, 6'd0);
        @(negedge clk);

        checkOutput("dec_state", state, 2'd1);
        checkOutput("dec_ir", ir, inst);
        checkOutput("dec_pc", pmem_addr, nextPc);
        checkOutput("dec_dmem_addr", dmem_addr, opnd);
        checkOutput("dec_strobes", {acc_we, dmem_we, alu_op, alu_src, halted}, 6'd0);
        @(negedge clk);

        checkOutput("exec_state", state, 2'd2);
        checkOutput("exec_pc", pmem_addr, nextPc);
        checkOutput("exec_strobes", {acc_we, dmem_we, alu_op, alu_src}, expectStrobes(op));
        checkOutput("exec_halted", halted, 1'b0);

        mPc = nextPc;
        mIr = inst;
        case (op)
            4'h1: mAcc = opnd;
            4'h2: mAcc = mMem[opnd];
            4'h3: mMem[opnd] = mAcc;
            4'h4: mAcc = mAcc + mMem[opnd];
            4'h5: mAcc = mAcc - mMem[opnd];
            4'h6: mAcc = mAcc & mMem[opnd];
            4'h7: mAcc = mAcc + opnd;
            4'h8: mPc = opnd;
            4'h9: if (mAcc == 8'h00) mPc = opnd;
            4'hA: if (mAcc != 8'h00) mPc = opnd;
            4'hF: hitHalt = 1'b1;
            default: ;
        endcase
        @(negedge clk);

        if (hitHalt) begin
            checkOutput("halt_state", state, 2'd3);
            checkOutput("halt_flag", halted, 1'b1);
            checkOutput("halt_pc", pmem_addr, mPc);
        end
    endtask

    task automatic applyStimulus(input int maxInstr, output bit sawHalt);
        bit h;
        sawHalt = 1'b0;
        for (int n = 0; n < maxInstr; n++) begin
            runInstr(h);
            if (h) begin
                sawHalt = 1'b1;
                break;
            end
        end
    endtask

    task automatic holdHalt(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            checkOutput("hold_state", state, 2'd3);
            checkOutput("hold_pc", pmem_addr, mPc);
            checkOutput("hold_ir", ir, mIr);
            checkOutput("hold_outputs", {acc_we, dmem_we, alu_op, alu_src, halted}, 6'b000001);
        end
    endtask

    initial begin
        bit h;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mMem[i] = 8'h00;
        clearProg();

        // Reset in the middle of an ADD's DECODE
        prog[0] = 12'h410;
        resetDut();
        @(negedge clk);
        checkOutput("mid_dec_state", state, 2'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid_rst_state", state, 2'd0);
        checkOutput("mid_rst_pc", pmem_addr, 8'h00);
        checkOutput("mid_rst_ir", ir, 12'h000);
        checkOutput("mid_rst_strobes", {acc_we, dmem_we}, 2'b00);
        mPc = 8'h00; mAcc = 8'h00; mIr = 12'h000;

        // LDI 5; ADDI 3; STM 0x10; HLT, then hold in HALT and resume after reset
        clearProg();
        prog[0] = 12'h105; prog[1] = 12'h703; prog[2] = 12'h310; prog[3] = 12'hF00;
        resetDut();
        applyStimulus(8, h);
        checkOutput("prog1_halted", h, 1'b1);
        checkOutput("prog1_pc", pmem_addr, 8'h04);
        checkOutput("prog1_mem", envMem[8'h10], 8'h08);
        holdHalt(20);
        resetDut();
        checkOutput("resume_pc", pmem_addr, 8'h00);

        // JZ taken and not taken
        prog[0] = 12'h100; prog[1] = 12'h920; prog[2] = 12'hF00; prog[8'h20] = 12'hF00;
        resetDut();
        runInstr(h); runInstr(h);
        checkOutput("jz_taken", pmem_addr, 8'h20);
        prog[0] = 12'h101;
        resetDut();
        runInstr(h); runInstr(h);
        checkOutput("jz_not_taken", pmem_addr, 8'h02);

        // JNZ taken
        prog[0] = 12'h103; prog[1] = 12'hA30; prog[8'h30] = 12'hF00;
        resetDut();
        runInstr(h); runInstr(h);
        checkOutput("jnz_taken", pmem_addr, 8'h30);

        // JMP, undefined opcode, then wrap from 0xFF
        clearProg();
        prog[0] = 12'h807; prog[7] = 12'hC55; prog[8] = 12'h8FF;
        resetDut();
        runInstr(h);
        checkOutput("jmp_target", pmem_addr, 8'h07);
        runInstr(h);
        checkOutput("undef_pc", pmem_addr, 8'h08);
        runInstr(h);
        checkOutput("jmp_ff", pmem_addr, 8'hFF);
        runInstr(h);
        checkOutput("pc_wrap", pmem_addr, 8'h00);

        // Random programs against the reference model
        for (int t = 0; t < 12; t++) begin
            for (int a = 0; a < 256; a++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h0;
                prog[a] = {op, 8'($urandom_range(0, 255))};
            end
            resetDut();
            applyStimulus(60, h);
            if (h) holdHalt(3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mcu_control_unit.md
# mcu_control_unit

Sequencing controller for the 8-bit accumulator MicroController datapath. It owns the program counter and instruction register and steps every instruction through FETCH, DECODE and EXECUTE. It drives the strobes for the accumulator, ALU, data memory and PC-update logic. It sits between program memory, data memory and the ALU/accumulator inside the MicroController top level.

## Interface
Parameters:
- PC_W, 8, program counter / program memory address width
- IR_W, 12, instruction width: opcode = ir[11:8], operand = ir[7:0]

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- pmem_data  in  12  instruction word at pmem_addr (combinational program memory read)
- acc_zero  in  1  1 when accumulator == 0 (registered in datapath)
- pmem_addr  out  8  equals pc register
- ir  out  12  instruction register
- dmem_addr  out  8  equals ir[7:0]
- dmem_we  out  1  data memory write strobe (data = accumulator)
- acc_we  out  1  accumulator load strobe (acc <= ALU result)
- alu_op  out  2  0 PASS_B, 1 ADD, 2 SUB, 3 AND
- alu_src  out  1  ALU B operand: 0 = data memory read data, 1 = ir[7:0] immediate
- halted  out  1  1 while in HALT state
- state  out  2  0 FETCH, 1 DECODE, 2 EXEC, 3 HALT (debug)

## Operation
- Reset: pc = 0x00, ir = 0x000, state = FETCH. dmem_we, acc_we, alu_op, alu_src and halted are all 0.
- FETCH: ir <= pmem_data; pc <= pc + 1 (8-bit, 0xFF wraps to 0x00); next state DECODE.
- DECODE: dmem_addr is valid, so the synchronous data memory read completes this cycle. No strobes. Next state EXEC.
- EXEC: strobes are a Moore decode of the state and ir[11:8]. Next state FETCH, except for HLT, which goes to HALT.
- Opcodes:
  - 0x0 NOP: no strobes.
  - 0x1 LDI: acc_we=1, alu_op=PASS_B, alu_src=1.
  - 0x2 LDM: acc_we=1, alu_op=PASS_B, alu_src=0.
  - 0x3 STM: dmem_we=1.
  - 0x4 ADD: acc_we=1, alu_op=ADD, alu_src=0.
  - 0x5 SUB: acc_we=1, alu_op=SUB, alu_src=0.
  - 0x6 AND: acc_we=1, alu_op=AND, alu_src=0.
  - 0x7 ADDI: acc_we=1, alu_op=ADD, alu_src=1.
  - 0x8 JMP: pc <= ir[7:0].
  - 0x9 JZ: pc <= ir[7:0] if acc_zero=1.
  - 0xA JNZ: pc <= ir[7:0] if acc_zero=0.
  - 0xF HLT: no strobes; enter HALT.
  - 0xB–0xE: treated as NOP.
- Jump condition samples acc_zero during EXEC. acc_zero reflects the previous instruction's result, because that result was registered at the end of the prior EXEC.
- Strobes are 0 in every state other than EXEC. alu_op and alu_src are 0 outside EXEC.
- HALT: pc and ir frozen, halted=1, all strobes 0. Only reset leaves HALT.
- Reset has priority over every state, including mid-instruction. The next edge forces the reset values, and no strobe fires in the cycle after reset is sampled.

## Timing
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXEC). There are no stalls.
- ir and pc update on the FETCH edge. pmem_addr in DECODE/EXEC already shows pc+1.
- Jump target is visible on pmem_addr in the first cycle after EXEC, which is the next FETCH.
- dmem_we and acc_we are high for exactly one cycle per applicable instruction, during EXEC.
- After reset deasserts, the first FETCH reads address 0x00 in that same cycle.
- HLT: halted rises in the cycle after EXEC and stays high until reset.

## Test plan
- Reset mid-DECODE of an ADD: assert reset for 1 cycle -> next cycle state=FETCH, pc=0x00, ir=0x000, acc_we=0, dmem_we=0.
- Program LDI 0x05; ADDI 0x03; STM 0x10; HLT -> acc_we pulses in cycles 3 and 6, with alu_src=1 and alu_op PASS_B then ADD. dmem_we pulses in cycle 9 with dmem_addr=0x10. halted=1 from cycle 13 with pc=0x04.
- JZ with acc_zero=1 (LDI 0x00; JZ 0x20) -> pmem_addr=0x20 at the next FETCH. Repeat with acc_zero=0 -> pmem_addr=0x02.
- JNZ/JMP: JMP 0x07 at address 0x00 -> pc=0x07. Undefined opcode 0xC -> no strobes and pc increments by 1.
- PC wrap: JMP 0xFF, with a NOP at 0xFF -> after fetching 0xFF, pc=0x00.
- HALT hold: after HLT, run 20 cycles -> pc, ir and state unchanged, all strobes 0. Reset -> resumes fetching at 0x00.
